lsu_dram_seq: RTL and testbench
===============================

Name: lsu_dram_seq

Overview:
- Load/store sequencer between the MEM pipeline stage and the 64-bit doubleword DRAM controller.
- Converts byte/half/word/double RV64 loads and stores into doubleword-aligned DRAM accesses.
- Performs read-modify-write for sub-doubleword stores and sign/zero-extends load data.
- Reports misaligned, out-of-range and conflicting requests, and holds the pipeline via busy.

Parameters:
- DRAM_BASE, 64'h8000_0000, first byte address mapped to DRAM.
- DRAM_BYTES, 65536, DRAM size in bytes; must be a multiple of 8.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  MEM stage presents a request this cycle.
- rd_ctrl  in  3  000 none, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 LW, 110 LWU, 111 LD.
- wr_ctrl  in  3  000 none, 001 SB, 010 SH, 011 SW, 100 SD, others reserved (= fault 11).
- addr  in  64  byte address.
- wdata  in  64  store data; low bytes used for sub-doubleword stores.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse; request completed.
- rdata  out  64  extended load result; valid when done is high and the op is a load, held until the next done.
- err  out  2  00 ok, 01 misaligned, 10 out of range, 11 rd/wr conflict or reserved code; valid with done.
- mem_en  out  1  DRAM access strobe.
- mem_we  out  1  DRAM write when mem_en is high.
- mem_addr  out  64  doubleword-aligned byte address ({addr[63:3],3'b000}).
- mem_wdata  out  64  full doubleword to write.
- mem_rdata  in  64  DRAM read data; valid in the cycle after a read strobe.

Behaviour:
- Reset values:
  - state IDLE.
  - busy=0, done=0, rdata=0, err=00.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- FSM states: IDLE, RD_ISSUE, RD_CAPT, MERGE, WR_ISSUE, DONE.
- Mem outputs are decoded from the state register and the latched request, with no combinational path from req inputs.
- Accept rule:
  - A request is accepted in IDLE when req_valid=1 and rd_ctrl or wr_ctrl is nonzero. This cycle is C0.
  - addr, ctrl fields, wdata and offset=addr[2:0] are latched at the C0 edge.
  - In non-IDLE states, req inputs are ignored. The pipeline must hold the request stable while busy.
- Fault checks, evaluated at C0 in this priority order:
  - Both ctrl fields nonzero, or a reserved wr code -> err 11.
  - Address misaligned (size 2: addr[0]; 4: addr[1:0]; 8: addr[2:0]) -> err 01.
  - addr < DRAM_BASE or addr+size > DRAM_BASE+DRAM_BYTES -> err 10.
  - Any fault: next state DONE, no mem_en asserted, rdata unchanged.
- Load path: C1 RD_ISSUE (mem_en=1, we=0) -> C2 RD_CAPT -> C3 DONE (done=1).
  - At the C2 edge, the selected field of mem_rdata (byte lane = offset) is captured into rdata.
  - LB/LH/LW sign-extend; LBU/LHU/LWU zero-extend.
- SD path: C1 WR_ISSUE (mem_en=1, we=1, mem_wdata=wdata) -> C2 DONE.
- SB/SH/SW path: C1 RD_ISSUE -> C2 MERGE -> C3 WR_ISSUE -> C4 DONE.
  - MERGE latches mem_rdata with the wdata low bytes replaced at lanes offset..offset+size-1.
  - WR_ISSUE writes the merged doubleword.
- DONE lasts exactly one cycle and always returns to IDLE. A new request can be accepted in the cycle after DONE.
- busy is high from C1 through DONE inclusive. busy is low in C0, so the pipeline stall derives from busy together with req_valid.
- Reset during any state:
  - Returns to IDLE immediately.
  - A pending RMW write is dropped. DRAM may hold pre-merge data; this is acceptable.
- Sub-word byte lanes are little-endian: lane k = bits [8k+7:8k].

Decomposition:
- Shared package rvcpu_mem_pkg holds:
  - rd_ctrl and wr_ctrl encodings.
  - err codes.
  - FSM state encoding (3-bit localparams).
  - Size decode function (ctrl -> 1/2/4/8).
- Sub-module mem_lane_align (purely combinational) holds:
  - Load extract/extend: rdata64, offset, rd_ctrl -> result.
  - Store merge: old64, wdata, offset, size -> merged64.
  - The FSM top instantiates one copy.

Test Plan:
- LD at 0x8000_0010, DRAM word 0x1122334455667788:
  - mem_en read at C1; done at C3.
  - rdata=0x1122334455667788, err=00.
- LB at 0x8000_0013, same word:
  - rdata=0x0000000000000055.
  - Then LB of a byte 0x80 -> 0xFFFFFFFFFFFFFF80.
  - LBU of the same byte -> 0x80.
- SH 0xBEEF at 0x8000_0016 over 0x1122334455667788:
  - Read at C1, write at C3 with mem_wdata=0xBEEF334455667788.
  - done at C4.
- SD 0xDEADBEEFCAFEF00D at 0x8000_0008:
  - Single write at C1, done at C2.
  - No read strobe.
- LW at 0x8000_0002 -> done at C1, err=01, mem_en never high.
- LD at 0x7FFF_FFF8 -> err=10.
- rd=101 with wr=011 -> err=11.
- Assert rst in MERGE of an SB:
  - busy=0 and mem_en=0 immediately.
  - Next request accepted normally.

Source files
------------

// File: rtl/rvcpu_mem_pkg.sv
// Shared encodings for the LSU-to-DRAM path: control codes, error codes,
// sequencer state encoding and access-size decode.
package rvcpu_mem_pkg;

    localparam logic [2:0] RD_NONE = 3'b000;
    localparam logic [2:0] RD_LB   = 3'b001;
    localparam logic [2:0] RD_LBU  = 3'b010;
    localparam logic [2:0] RD_LH   = 3'b011;
    localparam logic [2:0] RD_LHU  = 3'b100;
    localparam logic [2:0] RD_LW   = 3'b101;
    localparam logic [2:0] RD_LWU  = 3'b110;
    localparam logic [2:0] RD_LD   = 3'b111;

    localparam logic [2:0] WR_NONE = 3'b000;
    localparam logic [2:0] WR_SB   = 3'b001;
    localparam logic [2:0] WR_SH   = 3'b010;
    localparam logic [2:0] WR_SW   = 3'b011;
    localparam logic [2:0] WR_SD   = 3'b100;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;
    localparam logic [1:0] ERR_CONFLICT = 2'b11;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RD_ISSUE = 3'd1;
    localparam logic [2:0] ST_RD_CAPT  = 3'd2;
    localparam logic [2:0] ST_MERGE    = 3'd3;
    localparam logic [2:0] ST_WR_ISSUE = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

    // Access width in bytes; a load code takes precedence, 0 means no valid access.
    function automatic logic [3:0] access_size(input logic [2:0] rd_ctrl, input logic [2:0] wr_ctrl);
        logic [3:0] sz;
        sz = 4'd0;
        if (rd_ctrl != RD_NONE) begin
            case (rd_ctrl)
                RD_LB, RD_LBU: sz = 4'd1;
                RD_LH, RD_LHU: sz = 4'd2;
                RD_LW, RD_LWU: sz = 4'd4;
                RD_LD:         sz = 4'd8;
                default:       sz = 4'd0;
            endcase
        end else begin
            case (wr_ctrl)
                WR_SB:   sz = 4'd1;
                WR_SH:   sz = 4'd2;
                WR_SW:   sz = 4'd4;
                WR_SD:   sz = 4'd8;
                default: sz = 4'd0;
            endcase
        end
        return sz;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between a 64-bit DRAM doubleword and sub-doubleword
// accesses: load extract/extend and store merge. Purely combinational.
module mem_lane_align
    import rvcpu_mem_pkg::*;
(
    input  logic [63:0] rdata64,
    input  logic [2:0]  offset,
    input  logic [2:0]  rd_ctrl,
    output logic [63:0] ld_result,
    input  logic [63:0] old64,
    input  logic [63:0] wdata,
    input  logic [3:0]  size,
    output logic [63:0] merged64
);

    logic [5:0]  shamt_s;
    logic [63:0] shifted_s;
    logic [63:0] lane_mask_s;
    logic [63:0] mask_s;

    assign shamt_s = {offset, 3'b000};

    // Load: bring the addressed lane down to bit 0, then extend per opcode.
    always_comb begin
        shifted_s = rdata64 >> shamt_s;
        case (rd_ctrl)
            RD_LB:   ld_result = {{56{shifted_s[7]}}, shifted_s[7:0]};
            RD_LBU:  ld_result = {56'd0, shifted_s[7:0]};
            RD_LH:   ld_result = {{48{shifted_s[15]}}, shifted_s[15:0]};
            RD_LHU:  ld_result = {48'd0, shifted_s[15:0]};
            RD_LW:   ld_result = {{32{shifted_s[31]}}, shifted_s[31:0]};
            RD_LWU:  ld_result = {32'd0, shifted_s[31:0]};
            RD_LD:   ld_result = shifted_s;
            default: ld_result = 64'd0;
        endcase
    end

    // Store: replace only the lanes offset..offset+size-1 of the old doubleword.
    always_comb begin
        case (size)
            4'd1:    lane_mask_s = 64'h0000_0000_0000_00FF;
            4'd2:    lane_mask_s = 64'h0000_0000_0000_FFFF;
            4'd4:    lane_mask_s = 64'h0000_0000_FFFF_FFFF;
            default: lane_mask_s = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        mask_s   = lane_mask_s << shamt_s;
        merged64 = (old64 & ~mask_s) | ((wdata << shamt_s) & mask_s);
    end

endmodule

// File: rtl/lsu_dram_seq.sv
// Load/store sequencer: turns RV64 byte..double accesses into aligned DRAM
// doubleword reads, writes and read-modify-writes; all outputs are flops.
module lsu_dram_seq
    import rvcpu_mem_pkg::*;
#(
    parameter logic [63:0] DRAM_BASE  = 64'h8000_0000,
    parameter int unsigned DRAM_BYTES = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [2:0]  rd_ctrl,
    input  logic [2:0]  wr_ctrl,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [63:0] rdata,
    output logic [1:0]  err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);

    localparam logic [64:0] DRAM_LIMIT = {1'b0, DRAM_BASE} + 65'(DRAM_BYTES);

    logic [2:0]  state_q, state_d;
    logic [2:0]  rd_q, rd_d;
    logic [2:0]  wr_q, wr_d;
    logic [2:0]  offset_q, offset_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] rdata_q, rdata_d;
    logic [1:0]  err_q, err_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        mem_en_q, mem_en_d;
    logic        mem_we_q, mem_we_d;
    logic [63:0] mem_addr_q, mem_addr_d;
    logic [63:0] mem_wdata_q, mem_wdata_d;

    logic        accept_s;
    logic [3:0]  req_size_s;
    logic [64:0] req_end_s;
    logic        misalign_s;
    logic [1:0]  fault_s;
    logic [63:0] ld_result_s;
    logic [63:0] merged_s;

    mem_lane_align u_align (
        .rdata64   (mem_rdata),
        .offset    (offset_q),
        .rd_ctrl   (rd_q),
        .ld_result (ld_result_s),
        .old64     (mem_rdata),
        .wdata     (wdata_q),
        .size      (access_size(rd_q, wr_q)),
        .merged64  (merged_s)
    );

    // Request fault classification, highest priority first.
    always_comb begin
        accept_s   = req_valid && ((rd_ctrl != RD_NONE) || (wr_ctrl != WR_NONE));
        req_size_s = access_size(rd_ctrl, wr_ctrl);
        req_end_s  = {1'b0, addr} + {61'd0, req_size_s};
        case (req_size_s)
            4'd2:    misalign_s = addr[0];
            4'd4:    misalign_s = |addr[1:0];
            4'd8:    misalign_s = |addr[2:0];
            default: misalign_s = 1'b0;
        endcase
        if (((rd_ctrl != RD_NONE) && (wr_ctrl != WR_NONE)) || (wr_ctrl > WR_SD)) begin
            fault_s = ERR_CONFLICT;
        end else if (misalign_s) begin
            fault_s = ERR_MISALIGN;
        end else if ((addr < DRAM_BASE) || (req_end_s > DRAM_LIMIT)) begin
            fault_s = ERR_RANGE;
        end else begin
            fault_s = ERR_OK;
        end
    end

    // Sequencer next state and request latching.
    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        offset_d    = offset_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    rd_d       = rd_ctrl;
                    wr_d       = wr_ctrl;
                    offset_d   = addr[2:0];
                    wdata_d    = wdata;
                    err_d      = fault_s;
                    mem_addr_d = {addr[63:3], 3'b000};
                    if (fault_s != ERR_OK) begin
                        state_d = ST_DONE;
                    end else if ((rd_ctrl == RD_NONE) && (wr_ctrl == WR_SD)) begin
                        state_d     = ST_WR_ISSUE;
                        mem_wdata_d = wdata;
                    end else begin
                        state_d = ST_RD_ISSUE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_ISSUE: begin
                if (rd_q != RD_NONE) begin
                    state_d = ST_RD_CAPT;
                end else begin
                    state_d = ST_MERGE;
                end
            end
            ST_RD_CAPT: begin
                rdata_d = ld_result_s;
                state_d = ST_DONE;
            end
            ST_MERGE: begin
                mem_wdata_d = merged_s;
                state_d     = ST_WR_ISSUE;
            end
            ST_WR_ISSUE: state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Output flops are loaded from the next state so they line up with it.
    always_comb begin
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_DONE);
        mem_en_d = (state_d == ST_RD_ISSUE) || (state_d == ST_WR_ISSUE);
        mem_we_d = (state_d == ST_WR_ISSUE);
    end

    // State and output registers; reset drops any in-flight RMW write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rd_q        <= RD_NONE;
            wr_q        <= WR_NONE;
            offset_q    <= 3'd0;
            wdata_q     <= 64'd0;
            rdata_q     <= 64'd0;
            err_q       <= ERR_OK;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 64'd0;
            mem_wdata_q <= 64'd0;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            offset_q    <= offset_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign err       = err_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_dram_seq.sv
// Bench for lsu_dram_seq: behavioural DRAM plus a byte-array reference model,
// directed cases followed by randomized loads and stores.
module tb_lsu_dram_seq;

    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int          BYTES = 65536;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [2:0]  rd_ctrl, wr_ctrl;
    logic [63:0] addr, wdata;
    logic        busy, done;
    logic [63:0] rdata;
    logic [1:0]  err;
    logic        mem_en, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [63:0] mem_rdata = 64'd0;

    logic [63:0] dram    [0:8191];
    logic [7:0]  ref_mem [0:65535];
    logic [63:0] exp_rdata_hold = 64'd0;

    int errors = 0;
    int checks = 0;

    lsu_dram_seq #(.DRAM_BASE(BASE), .DRAM_BYTES(BYTES)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .rd_ctrl(rd_ctrl), .wr_ctrl(wr_ctrl),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata), .err(err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // DRAM: read data appears the cycle after the strobe
    always @(posedge clk) begin
        if (mem_en && mem_addr >= BASE && mem_addr < BASE + 64'(BYTES)) begin
            if (mem_we) dram[mem_addr[15:3]] <= mem_wdata;
            else        mem_rdata <= dram[mem_addr[15:3]];
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_dword(input int idx, input logic [63:0] v);
        dram[idx] <= v;
        for (int b = 0; b < 8; b++) ref_mem[idx*8 + b] = v[8*b +: 8];
    endtask

    function automatic int size_of(input logic [2:0] r, input logic [2:0] w);
        if (r == 3'd1 || r == 3'd2) return 1;
        if (r == 3'd3 || r == 3'd4) return 2;
        if (r == 3'd5 || r == 3'd6) return 4;
        if (r == 3'd7) return 8;
        if (w == 3'd1) return 1;
        if (w == 3'd2) return 2;
        if (w == 3'd3) return 4;
        if (w == 3'd4) return 8;
        return 0;
    endfunction

    function automatic logic [1:0] model_err(input logic [2:0] r, input logic [2:0] w, input logic [63:0] a);
        int sz;
        logic [64:0] end_a;
        if ((r != 3'd0 && w != 3'd0) || w > 3'd4) return 2'b11;
        sz = size_of(r, w);
        if ((a % 64'(sz)) != 64'd0) return 2'b01;
        end_a = {1'b0, a} + 65'(sz);
        if (a < BASE || end_a > {1'b0, BASE} + 65'(BYTES)) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [63:0] model_load(input logic [2:0] r, input logic [63:0] a);
        logic [63:0] diff, v;
        int off, sz;
        diff = a - BASE;
        off  = int'(diff[15:0]);
        sz   = size_of(r, 3'd0);
        v    = 64'd0;
        for (int i = 0; i < sz; i++) v = v | (64'(ref_mem[off + i]) << (8 * i));
        if ((r == 3'd1 || r == 3'd3 || r == 3'd5) && sz < 8 && v[8*sz-1])
            v = v | ~((64'd1 << (8 * sz)) - 64'd1);
        return v;
    endfunction

    function automatic logic [63:0] model_dword(input logic [63:0] a);
        logic [63:0] diff, v;
        int base_off;
        diff     = a - BASE;
        base_off = int'(diff[15:0]) & ~7;
        v        = 64'd0;
        for (int i = 0; i < 8; i++) v = v | (64'(ref_mem[base_off + i]) << (8 * i));
        return v;
    endfunction

    task automatic run_req(input logic [2:0] r, input logic [2:0] w, input logic [63:0] a,
                           input logic [63:0] d, output logic [63:0] o_rdata,
                           output logic [63:0] o_wdata, output logic [1:0] o_err);
        logic [1:0]  e;
        int          sz, exp_done, exp_rd, exp_wr;
        int          done_cyc, rd_cyc, wr_cyc, rd_cnt, wr_cnt;
        logic [63:0] exp_wd, wd, wa, ra, diff;
        e  = model_err(r, w, a);
        sz = size_of(r, w);
        exp_done = (e != 2'b00) ? 1 : (r != 3'd0) ? 3 : (w == 3'd4) ? 2 : 4;
        exp_rd   = (e == 2'b00 && !(r == 3'd0 && w == 3'd4)) ? 1 : 0;
        exp_wr   = (e != 2'b00 || r != 3'd0) ? 0 : (w == 3'd4) ? 1 : 3;
        exp_wd   = 64'd0;
        if (e == 2'b00 && r != 3'd0) exp_rdata_hold = model_load(r, a);
        if (e == 2'b00 && r == 3'd0) begin
            diff = a - BASE;
            for (int i = 0; i < sz; i++) ref_mem[int'(diff[15:0]) + i] = d[8*i +: 8];
            exp_wd = model_dword(a);
        end
        done_cyc = 0; rd_cyc = 0; wr_cyc = 0; rd_cnt = 0; wr_cnt = 0;
        wd = 64'd0; wa = 64'd0; ra = 64'd0;

        @(posedge clk); #1;
        check("c0_busy", 64'(busy), 64'd0);
        req_valid = 1'b1; rd_ctrl = r; wr_ctrl = w; addr = a; wdata = d;
        for (int cyc = 1; cyc <= 8 && done_cyc == 0; cyc++) begin
            @(posedge clk); #1;
            if (mem_en) begin
                if (mem_we) begin wr_cnt++; wr_cyc = cyc; wd = mem_wdata; wa = mem_addr; end
                else        begin rd_cnt++; rd_cyc = cyc; ra = mem_addr; end
            end
            check("busy_hi", 64'(busy), 64'd1);
            if (done) done_cyc = cyc;
        end
        req_valid = 1'b0; rd_ctrl = 3'd0; wr_ctrl = 3'd0;
        check("done_cyc", 64'(done_cyc), 64'(exp_done));
        check("rd_cnt", 64'(rd_cnt), 64'(exp_rd));
        check("rd_cyc", 64'(rd_cyc), 64'(exp_rd));
        check("wr_cnt", 64'(wr_cnt), 64'(exp_wr != 0));
        check("wr_cyc", 64'(wr_cyc), 64'(exp_wr));
        check("err", 64'(err), 64'(e));
        check("rdata", rdata, exp_rdata_hold);
        if (exp_rd != 0) check("rd_addr", ra, {a[63:3], 3'b000});
        if (exp_wr != 0) begin
            check("wr_addr", wa, {a[63:3], 3'b000});
            check("wr_data", wd, exp_wd);
        end
        o_rdata = rdata; o_wdata = wd; o_err = err;
        @(posedge clk); #1;
        check("done_pulse", 64'(done), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        logic [63:0] o_rd, o_wd, a, d;
        logic [1:0]  o_e;
        logic [2:0]  r, w;
        int          sz, mode;

        rst = 1'b1; req_valid = 1'b0; rd_ctrl = 3'd0; wr_ctrl = 3'd0;
        addr = 64'd0; wdata = 64'd0;
        for (int i = 0; i < 8192; i++) set_dword(i, {$urandom, $urandom});
        set_dword(2, 64'h1122_3344_5566_7788);
        set_dword(4, 64'h0000_0000_0000_0080);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rdata", rdata, 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_mem_en", 64'(mem_en), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_mem_wdata", mem_wdata, 64'd0);
        rst = 1'b0;

        run_req(3'b111, 3'd0, 64'h8000_0010, 64'd0, o_rd, o_wd, o_e);
        check("ld_value", o_rd, 64'h1122_3344_5566_7788);
        run_req(3'b001, 3'd0, 64'h8000_0013, 64'd0, o_rd, o_wd, o_e);
        check("lb_value", o_rd, 64'h0000_0000_0000_0055);
        run_req(3'b001, 3'd0, 64'h8000_0020, 64'd0, o_rd, o_wd, o_e);
        check("lb_neg", o_rd, 64'hFFFF_FFFF_FFFF_FF80);
        run_req(3'b010, 3'd0, 64'h8000_0020, 64'd0, o_rd, o_wd, o_e);
        check("lbu_value", o_rd, 64'h0000_0000_0000_0080);
        run_req(3'd0, 3'b010, 64'h8000_0016, 64'h0000_0000_0000_BEEF, o_rd, o_wd, o_e);
        check("sh_merge", o_wd, 64'hBEEF_3344_5566_7788);
        run_req(3'd0, 3'b100, 64'h8000_0008, 64'hDEAD_BEEF_CAFE_F00D, o_rd, o_wd, o_e);
        check("sd_data", o_wd, 64'hDEAD_BEEF_CAFE_F00D);
        run_req(3'b111, 3'd0, 64'h8000_0008, 64'd0, o_rd, o_wd, o_e);
        run_req(3'b101, 3'd0, 64'h8000_0002, 64'd0, o_rd, o_wd, o_e);
        check("lw_misalign", 64'(o_e), 64'd1);
        run_req(3'b111, 3'd0, 64'h7FFF_FFF8, 64'd0, o_rd, o_wd, o_e);
        check("ld_below", 64'(o_e), 64'd2);
        run_req(3'b101, 3'b011, 64'h8000_0000, 64'd0, o_rd, o_wd, o_e);
        check("conflict", 64'(o_e), 64'd3);
        run_req(3'd0, 3'b110, 64'h8000_0000, 64'd0, o_rd, o_wd, o_e);
        check("reserved_wr", 64'(o_e), 64'd3);
        run_req(3'b111, 3'd0, BASE + 64'(BYTES) - 64'd8, 64'd0, o_rd, o_wd, o_e);
        check("ld_top_ok", 64'(o_e), 64'd0);
        run_req(3'b110, 3'd0, BASE + 64'(BYTES) - 64'd4, 64'd0, o_rd, o_wd, o_e);
        run_req(3'b111, 3'd0, BASE + 64'(BYTES), 64'd0, o_rd, o_wd, o_e);
        check("ld_past_top", 64'(o_e), 64'd2);
        run_req(3'd0, 3'b011, BASE + 64'(BYTES) - 64'd4, 64'h1234_5678, o_rd, o_wd, o_e);

        // Reset while an SB sits in MERGE: the write must never reach DRAM
        @(posedge clk); #1;
        req_valid = 1'b1; rd_ctrl = 3'd0; wr_ctrl = 3'b001; addr = 64'h8000_0031; wdata = 64'hAA;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_mem_en", 64'(mem_en), 64'd0);
        check("rst_mid_rdata", rdata, 64'd0);
        exp_rdata_hold = 64'd0;
        req_valid = 1'b0; wr_ctrl = 3'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        run_req(3'b010, 3'd0, 64'h8000_0031, 64'd0, o_rd, o_wd, o_e);

        for (int n = 0; n < 60; n++) begin
            r = 3'($urandom_range(0, 7));
            w = 3'($urandom_range(0, 4));
            if ($urandom_range(0, 1) == 0) r = 3'd0; else w = 3'd0;
            if ($urandom_range(0, 14) == 0) begin r = 3'($urandom_range(1, 7)); w = 3'($urandom_range(1, 7)); end
            if (r == 3'd0 && w == 3'd0) r = 3'd7;
            sz   = size_of(r, w);
            mode = $urandom_range(0, 9);
            a    = BASE + 64'($urandom_range(0, 511));
            if (mode < 8 && sz > 0) a = a & ~(64'(sz) - 64'd1);
            else if (mode == 8)     a = BASE + 64'(BYTES) - 64'($urandom_range(0, 8));
            d = {$urandom, $urandom};
            run_req(r, w, a, d, o_rd, o_wd, o_e);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
